// File: rtl/reg_write_arbiter.sv
// Round-robin / fixed-priority arbiter for a load-enable register bank: one write per edge.
// Requests sampled at edge k drive registered GNT/LOAD_EN/REG_IN in cycle k+1. A requester holds its request until it sees its grant.
module reg_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 2,
    parameter int NUM_REGS   = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             MODE,
    input  logic [NUM_REQ-1:0]               REQ,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    WADDR,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    WDATA,
    output logic [NUM_REQ-1:0]               GNT,
    output logic [NUM_REGS-1:0]              LOAD_EN,
    output logic [DATA_WIDTH-1:0]            REG_IN,
    output logic                             ERR,
    output logic                             BUSY
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]      ptr;
    logic [PTR_W-1:0]      ptr_nxt;
    logic [NUM_REQ-1:0]    elig;
    logic [PTR_W-1:0]      win;
    logic                  win_vld;
    logic [NUM_REQ-1:0]    gnt_nxt;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_data;
    logic                  addr_ok;
    logic [NUM_REGS-1:0]   load_nxt;

    logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i] = WADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign data_arr[i] = WDATA[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // The requester granted last cycle is masked so a held REQ cannot write twice in a row.
    assign elig = REQ & ~GNT;

    always_comb begin
        int base;
        int idx;
        win     = '0;
        win_vld = 1'b0;
        base    = MODE ? 0 : int'(ptr);
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = base + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!win_vld && elig[idx]) begin
                win_vld = 1'b1;
                win     = PTR_W'(idx);
            end
        end
    end

    assign win_addr = addr_arr[win];
    assign win_data = data_arr[win];
    assign addr_ok  = 32'(win_addr) < 32'(NUM_REGS);
    assign ptr_nxt  = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;

    always_comb begin
        gnt_nxt  = '0;
        load_nxt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt_nxt[i] = win_vld && (win == PTR_W'(i));
        end
        for (int r = 0; r < NUM_REGS; r++) begin
            load_nxt[r] = win_vld && addr_ok && (32'(win_addr) == 32'(r));
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            GNT     <= '0;
            LOAD_EN <= '0;
            REG_IN  <= '0;
            ERR     <= 1'b0;
            ptr     <= '0;
        end else if (win_vld) begin
            GNT     <= gnt_nxt;
            LOAD_EN <= load_nxt;
            REG_IN  <= win_data;
            ERR     <= !addr_ok;
            ptr     <= ptr_nxt;
        end else begin
            // REG_IN and the pointer hold while idle.
            GNT     <= '0;
            LOAD_EN <= '0;
            ERR     <= 1'b0;
        end
    end

    assign BUSY = |GNT;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Randomized and directed bench for reg_write_arbiter against a behavioural model of the arbitration rules.
module tb_reg_write_arbiter;

    localparam int NR = 4;
    localparam int DW = 2;
    localparam int NG = 4;
    localparam int AW = 2;

    logic             CLK = 1'b0;
    logic             RST;
    logic             MODE;
    logic [NR-1:0]    REQ;
    logic [NR*AW-1:0] WADDR;
    logic [NR*DW-1:0] WDATA;
    logic [NR-1:0]    GNT;
    logic [NG-1:0]    LOAD_EN;
    logic [DW-1:0]    REG_IN;
    logic             ERR;
    logic             BUSY;

    logic [NR-1:0]    req3;
    logic [NR*AW-1:0] waddr3;
    logic [NR*DW-1:0] wdata3;
    logic [NR-1:0]    gnt3;
    logic [2:0]       load_en3;
    logic [DW-1:0]    reg_in3;
    logic             err3;
    logic             busy3;

    reg_write_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .NUM_REGS(NG), .ADDR_WIDTH(AW)) u_dut (
        .CLK(CLK), .RST(RST), .MODE(MODE), .REQ(REQ), .WADDR(WADDR), .WDATA(WDATA),
        .GNT(GNT), .LOAD_EN(LOAD_EN), .REG_IN(REG_IN), .ERR(ERR), .BUSY(BUSY)
    );

    reg_write_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .NUM_REGS(3), .ADDR_WIDTH(AW)) u_dut3 (
        .CLK(CLK), .RST(RST), .MODE(1'b0), .REQ(req3), .WADDR(waddr3), .WDATA(wdata3),
        .GNT(gnt3), .LOAD_EN(load_en3), .REG_IN(reg_in3), .ERR(err3), .BUSY(busy3)
    );

    always #5 CLK = ~CLK;

    int vectors     = 0;
    int miscompares = 0;

    // Model state: granted requester (-1 = none), rotation start, last data, error, loaded register.
    int m_gnt    = -1;
    int m_ptr    = 0;
    int m_reg_in = 0;
    int m_err    = 0;
    int m_load   = -1;
    int bank_m [NG];
    int bank_d [NG];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_gnt = -1; m_ptr = 0; m_reg_in = 0; m_err = 0; m_load = -1;
    endtask

    // One arbitration edge: eligible = requesting and not granted last cycle.
    task automatic model_edge();
        int order [$];
        int w;
        int a;
        int d;
        w = -1;
        for (int k = 0; k < NR; k++) begin
            order.push_back(MODE ? k : (m_ptr + k) % NR);
        end
        foreach (order[j]) begin
            if (w < 0 && REQ[order[j]] && order[j] != m_gnt) w = order[j];
        end
        if (w < 0) begin
            m_gnt = -1; m_load = -1; m_err = 0;
        end else begin
            a = int'(WADDR[w*AW +: AW]);
            d = int'(WDATA[w*DW +: DW]);
            m_gnt = w;
            m_reg_in = d;
            m_ptr = (w + 1) % NR;
            if (a < NG) begin
                m_load = a; m_err = 0; bank_m[a] = d;
            end else begin
                m_load = -1; m_err = 1;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check_val({tag, ".gnt"},    32'(GNT),     (m_gnt < 0)  ? 32'd0 : (32'd1 << m_gnt));
        check_val({tag, ".load"},   32'(LOAD_EN), (m_load < 0) ? 32'd0 : (32'd1 << m_load));
        check_val({tag, ".reg_in"}, 32'(REG_IN),  32'(m_reg_in));
        check_val({tag, ".err"},    32'(ERR),     32'(m_err));
        check_val({tag, ".busy"},   32'(BUSY),    32'(m_gnt >= 0));
        check_val({tag, ".gnt1h"},  32'($onehot0(GNT)),     32'd1);
        check_val({tag, ".load1h"}, 32'($onehot0(LOAD_EN)), 32'd1);
    endtask

    task automatic cycle(input string tag);
        @(posedge CLK);
        if (RST) model_reset();
        else     model_edge();
        @(negedge CLK);
        compare_all(tag);
        for (int r = 0; r < NG; r++) begin
            if (LOAD_EN[r]) bank_d[r] = int'(REG_IN);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        model_reset();
        cycle("rst");
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1; MODE = 1'b0; REQ = '0; WADDR = '0; WDATA = '0;
        req3 = '0; waddr3 = '0; wdata3 = '0;
        for (int r = 0; r < NG; r++) begin bank_m[r] = 0; bank_d[r] = 0; end

        // Reset held with every requester asking.
        REQ = 4'b1111;
        repeat (3) cycle("rst_hold");
        check_val("rst_gnt",  32'(GNT), 32'd0);
        check_val("rst_load", 32'(LOAD_EN), 32'd0);
        check_val("rst_busy", 32'(BUSY), 32'd0);
        REQ = '0;
        RST = 1'b0;

        // Lone requester: grant, masked cycle, re-grant.
        REQ = 4'b0100; WADDR[2*AW +: AW] = 2'd3; WDATA[2*DW +: DW] = 2'b10;
        cycle("single1");
        check_val("single1_gnt",  32'(GNT), 32'h4);
        check_val("single1_load", 32'(LOAD_EN), 32'h8);
        check_val("single1_data", 32'(REG_IN), 32'h2);
        check_val("single1_busy", 32'(BUSY), 32'h1);
        cycle("single2");
        check_val("single2_gnt", 32'(GNT), 32'h0);
        cycle("single3");
        check_val("single3_gnt", 32'(GNT), 32'h4);
        REQ = '0;
        cycle("idle");

        // Round-robin rotation from a fresh pointer.
        do_reset();
        MODE = 1'b0; REQ = 4'b1111;
        WADDR = {2'd0, 2'd1, 2'd2, 2'd3}; WDATA = {2'd3, 2'd1, 2'd2, 2'd0};
        for (int i = 0; i < 5; i++) begin
            cycle("rr");
            check_val("rr_gnt", 32'(GNT), 32'd1 << (i % NR));
            check_val("rr_data", 32'(REG_IN), 32'(WDATA[(i % NR)*DW +: DW]));
        end

        // Reset asserted mid-grant clears outputs immediately.
        #2 RST = 1'b1;
        #1;
        check_val("async_gnt",  32'(GNT), 32'd0);
        check_val("async_load", 32'(LOAD_EN), 32'd0);
        check_val("async_data", 32'(REG_IN), 32'd0);
        check_val("async_busy", 32'(BUSY), 32'd0);
        REQ = '0;
        do_reset();

        // Fixed priority alternating under masking, then a lower requester joins.
        MODE = 1'b1; REQ = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            cycle("fp");
            check_val("fp_gnt", 32'(GNT), (i % 2 == 0) ? 32'h2 : 32'h8);
        end
        REQ = 4'b1011;
        cycle("fp_join");
        check_val("fp_join_gnt", 32'(GNT), 32'h1);
        REQ = '0;
        cycle("idle");

        // Out-of-range address on the three-register instance.
        req3 = 4'b0001; waddr3[AW-1:0] = 2'd3; wdata3[DW-1:0] = 2'd1;
        cycle("oor");
        check_val("oor_gnt",  32'(gnt3), 32'h1);
        check_val("oor_load", 32'(load_en3), 32'h0);
        check_val("oor_err",  32'(err3), 32'h1);
        req3 = '0;
        cycle("oor_clr");
        check_val("oor_err_clr", 32'(err3), 32'h0);
        check_val("oor_gnt_clr", 32'(gnt3), 32'h0);
        req3 = 4'b0001; waddr3[AW-1:0] = 2'd2;
        cycle("inr");
        check_val("inr_load", 32'(load_en3), 32'h4);
        check_val("inr_err",  32'(err3), 32'h0);
        req3 = '0;

        // Random traffic obeying the hold-until-granted handshake.
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 15) == 0) MODE = ~MODE;
            for (int i = 0; i < NR; i++) begin
                if (!REQ[i] || GNT[i]) begin
                    REQ[i] = ($urandom_range(0, 2) != 0);
                    WADDR[i*AW +: AW] = AW'($urandom_range(0, NG - 1));
                    WDATA[i*DW +: DW] = DW'($urandom);
                end
            end
            cycle("rand");
        end
        REQ = '0;
        cycle("drain");
        for (int r = 0; r < NG; r++) begin
            check_val("bank", 32'(bank_d[r]), 32'(bank_m[r]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
